// File: rtl/ctrl_pipe_d_x.sv
// D-to-X control pipeline register with flush, load-use bubble and memory-freeze handling.
// Optional stall/flush performance counters are enabled by defining CTRL_PIPE_PERF_CNT_EN.
module ctrl_pipe_d_x #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_d,
  input  logic             reg_we_d,
  input  logic [1:0]       wb_sel_d,
  input  logic             mem_we_d,
  input  logic [4:0]       rd_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             use_rs1_d,
  input  logic             use_rs2_d,
  input  logic             flush_x,
  input  logic             mem_busy,
`ifdef CTRL_PIPE_PERF_CNT_EN
  input  logic             cnt_clr,
`endif
  output logic             valid_x,
  output logic             reg_we_x,
  output logic             mem_we_x,
  output logic [1:0]       wb_sel_x,
  output logic [4:0]       rd_x,
  output logic             stall_fd
`ifdef CTRL_PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic       lu_s;
  logic       nxt_valid_s;
  logic       nxt_reg_we_s;
  logic       nxt_mem_we_s;
  logic [1:0] nxt_wb_sel_s;
  logic [4:0] nxt_rd_s;

  // Load-use detection against the load currently held in X
  always_comb begin
    lu_s = 1'b0;
    if (valid_x && reg_we_x && (wb_sel_x == 2'd1) && (rd_x != 5'd0) && valid_d) begin
      lu_s = (use_rs1_d && (rs1_d == rd_x)) || (use_rs2_d && (rs2_d == rd_x));
    end else begin
      lu_s = 1'b0;
    end
  end

  assign stall_fd = mem_busy | (~flush_x & lu_s);

  // Candidate X bundle from D; invalid D collapses to a bubble, x0 writes are suppressed
  always_comb begin
    nxt_valid_s  = 1'b0;
    nxt_reg_we_s = 1'b0;
    nxt_mem_we_s = 1'b0;
    nxt_wb_sel_s = 2'd0;
    nxt_rd_s     = 5'd0;
    if (valid_d) begin
      nxt_valid_s  = 1'b1;
      nxt_reg_we_s = reg_we_d & (rd_d != 5'd0);
      nxt_mem_we_s = mem_we_d;
      nxt_wb_sel_s = wb_sel_d;
      nxt_rd_s     = rd_d;
    end else begin
      nxt_valid_s  = 1'b0;
    end
  end

  // X-stage register: freeze, bubble or advance, in that priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_x  <= 1'b0;
      reg_we_x <= 1'b0;
      mem_we_x <= 1'b0;
      wb_sel_x <= 2'd0;
      rd_x     <= 5'd0;
    end else if (mem_busy) begin
      valid_x  <= valid_x;
      reg_we_x <= reg_we_x;
      mem_we_x <= mem_we_x;
      wb_sel_x <= wb_sel_x;
      rd_x     <= rd_x;
    end else if (flush_x || lu_s) begin
      valid_x  <= 1'b0;
      reg_we_x <= 1'b0;
      mem_we_x <= 1'b0;
      wb_sel_x <= 2'd0;
      rd_x     <= 5'd0;
    end else begin
      valid_x  <= nxt_valid_s;
      reg_we_x <= nxt_reg_we_s;
      mem_we_x <= nxt_mem_we_s;
      wb_sel_x <= nxt_wb_sel_s;
      rd_x     <= nxt_rd_s;
    end
  end

`ifdef CTRL_PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating counters; the flush bubble takes precedence over the load-use bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else if (!mem_busy && flush_x) begin
      if (flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end else if (!mem_busy && lu_s) begin
      if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end
    end else begin
      stall_cnt <= stall_cnt;
      flush_cnt <= flush_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe_d_x.sv
// Scoreboard bench for ctrl_pipe_d_x: expected X bundles are queued when D is driven
// and compared after the clock edge; counter checks apply when CTRL_PIPE_PERF_CNT_EN is defined.
module tb_ctrl_pipe_d_x;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_d = 1'b0, reg_we_d = 1'b0, mem_we_d = 1'b0;
  logic [1:0] wb_sel_d = 2'd0;
  logic [4:0] rd_d = 5'd0, rs1_d = 5'd0, rs2_d = 5'd0;
  logic       use_rs1_d = 1'b0, use_rs2_d = 1'b0, flush_x = 1'b0, mem_busy = 1'b0;
  logic       valid_x, reg_we_x, mem_we_x, stall_fd;
  logic [1:0] wb_sel_x;
  logic [4:0] rd_x;
`ifdef CTRL_PIPE_PERF_CNT_EN
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  ctrl_pipe_d_x #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .reg_we_d(reg_we_d), .wb_sel_d(wb_sel_d),
    .mem_we_d(mem_we_d), .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d),
    .use_rs2_d(use_rs2_d), .flush_x(flush_x), .mem_busy(mem_busy),
`ifdef CTRL_PIPE_PERF_CNT_EN
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .valid_x(valid_x), .reg_we_x(reg_we_x), .mem_we_x(mem_we_x), .wb_sel_x(wb_sel_x),
    .rd_x(rd_x), .stall_fd(stall_fd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stall_seen = 0;
  int bub_seen = 0;

  // reference X state and counters
  logic       m_v = 1'b0, m_we = 1'b0, m_mwe = 1'b0;
  logic [1:0] m_ws = 2'd0;
  logic [4:0] m_rd = 5'd0;
  int         m_sc = 0, m_fc = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 1'b0; m_we = 1'b0; m_mwe = 1'b0; m_ws = 2'd0; m_rd = 5'd0;
    m_sc = 0; m_fc = 0;
  endtask

  // Drive one D bundle at the falling edge, check stall, queue expectation, compare after edge
  task automatic drive(input logic v, input logic we, input logic [1:0] ws, input logic mwe,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic fl, input logic mb,
                       input logic clr);
    logic lu, exp_stall;
    logic [9:0] e;
    valid_d = v; reg_we_d = we; wb_sel_d = ws; mem_we_d = mwe; rd_d = rd;
    rs1_d = r1; rs2_d = r2; use_rs1_d = u1; use_rs2_d = u2; flush_x = fl; mem_busy = mb;
`ifdef CTRL_PIPE_PERF_CNT_EN
    cnt_clr = clr;
`endif
    #1;
    lu = m_v && m_we && (m_ws == 2'd1) && (m_rd != 5'd0) && v &&
         ((u1 && (r1 == m_rd)) || (u2 && (r2 == m_rd)));
    exp_stall = mb | (!fl & lu);
    check("stall_fd", {31'd0, stall_fd}, {31'd0, exp_stall});
    if (stall_fd) stall_seen++;
`ifdef CTRL_PIPE_PERF_CNT_EN
    if (clr) begin
      m_sc = 0; m_fc = 0;
    end else if (!mb && fl) begin
      if (m_fc < CNT_MAX) m_fc++;
    end else if (!mb && lu) begin
      if (m_sc < CNT_MAX) m_sc++;
    end
`endif
    if (mb) begin
      // hold
    end else if (fl || lu || !v) begin
      m_v = 1'b0; m_we = 1'b0; m_mwe = 1'b0; m_ws = 2'd0; m_rd = 5'd0;
    end else begin
      m_v = 1'b1; m_we = we && (rd != 5'd0); m_mwe = mwe; m_ws = ws; m_rd = rd;
    end
    exp_q.push_back({m_v, m_we, m_mwe, m_ws, m_rd});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("valid_x", {31'd0, valid_x}, {31'd0, e[9]});
    check("reg_we_x", {31'd0, reg_we_x}, {31'd0, e[8]});
    check("mem_we_x", {31'd0, mem_we_x}, {31'd0, e[7]});
    check("wb_sel_x", {30'd0, wb_sel_x}, {30'd0, e[6:5]});
    check("rd_x", {27'd0, rd_x}, {27'd0, e[4:0]});
    if (!valid_x) bub_seen++;
`ifdef CTRL_PIPE_PERF_CNT_EN
    check("stall_cnt", {28'd0, stall_cnt}, m_sc);
    check("flush_cnt", {28'd0, flush_cnt}, m_fc);
`endif
  endtask

  // shorthands: load (wb_sel=1), ALU op (wb_sel=0)
  task automatic load(input logic [4:0] rd);
    drive(1'b1, 1'b1, 2'd1, 1'b0, rd, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic fl, input logic mb);
    drive(1'b1, 1'b1, 2'd0, 1'b0, rd, r1, r2, u1, u2, fl, mb, 1'b0);
  endtask

  initial begin
    int sc0, fc0;
    // reset with a live D bundle
    valid_d = 1'b1; reg_we_d = 1'b1; rd_d = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid_x", {31'd0, valid_x}, 32'd0);
    check("rst_reg_we_x", {31'd0, reg_we_x}, 32'd0);
`ifdef CTRL_PIPE_PERF_CNT_EN
    check("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    check("rst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    alu(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    check("first_rd_x", {27'd0, rd_x}, 32'd5);
    check("first_valid_x", {31'd0, valid_x}, 32'd1);

    // load-use on rs2: one stall, one bubble, then the add
    load(5'd7);
    stall_seen = 0; bub_seen = 0;
    alu(5'd10, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    alu(5'd10, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    check("lu_stall_cycles", stall_seen, 32'd1);
    check("lu_bubbles", bub_seen, 32'd1);
    check("lu_add_rd", {27'd0, rd_x}, 32'd10);

    // same pair but rs2 not read
    load(5'd7);
    stall_seen = 0;
    alu(5'd11, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("nouse_stall_cycles", stall_seen, 32'd0);

    // load to x0, then a use of x0
    load(5'd0);
    check("x0_reg_we_x", {31'd0, reg_we_x}, 32'd0);
    stall_seen = 0;
    alu(5'd12, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("x0_stall_cycles", stall_seen, 32'd0);

    // flush beats hazard
    load(5'd9);
`ifdef CTRL_PIPE_PERF_CNT_EN
    sc0 = m_sc; fc0 = m_fc;
`endif
    stall_seen = 0;
    alu(5'd13, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush_stall_cycles", stall_seen, 32'd0);
    check("flush_bubble", {31'd0, valid_x}, 32'd0);
`ifdef CTRL_PIPE_PERF_CNT_EN
    check("flush_cnt_inc", {28'd0, flush_cnt}, fc0 + 1);
    check("flush_stall_cnt_same", {28'd0, stall_cnt}, sc0);
`endif

    // memory freeze with a pending load-use
    load(5'd3);
    stall_seen = 0; bub_seen = 0;
    repeat (3) alu(5'd14, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("freeze_rd_x", {27'd0, rd_x}, 32'd3);
    alu(5'd14, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    alu(5'd14, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("freeze_stall_cycles", stall_seen, 32'd4);
    check("freeze_bubbles", bub_seen, 32'd1);
    check("freeze_rd_after", {27'd0, rd_x}, 32'd14);

    // asynchronous reset in the middle of a load-use stall
    load(5'd6);
    valid_d = 1'b1; use_rs1_d = 1'b1; rs1_d = 5'd6;
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid_x", {31'd0, valid_x}, 32'd0);
    check("arst_rd_x", {27'd0, rd_x}, 32'd0);
    check("arst_wb_sel_x", {30'd0, wb_sel_x}, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    alu(5'd15, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("arst_after_rd", {27'd0, rd_x}, 32'd15);

`ifdef CTRL_PIPE_PERF_CNT_EN
    // 20 load-use stalls saturate the 4-bit counter, then clear wins over a stall
    for (int i = 0; i < 20; i++) begin
      load(5'd4);
      alu(5'd8, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("stall_cnt_sat", {28'd0, stall_cnt}, 32'd15);
    load(5'd4);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 5'd8, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("stall_cnt_clr", {28'd0, stall_cnt}, 32'd0);
`endif

    // random traffic with a small register range to provoke hazards
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 31) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
